// File: rtl/binarize_sequencer.sv
// Two-pass frame sequencer: pass 1 feeds the histogram, waits for the threshold,
// pass 2 drives the output RAM. Optional read stall via `define BINSEQ_STALL_EN.
module binarize_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int NUM_PIXELS = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BINSEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic              thr_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              hist_valid,
  output logic              thr_start,
  output logic              enable,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE, PASS1, DRAIN1, CALC, PASS2, DRAIN2, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              hist_valid_q, hist_valid_d;
  logic              thr_start_q, thr_start_d;
  logic              done_seen_q, done_seen_d;
  logic              enable_q, enable_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              stall_w;
  logic              last_issued;

`ifdef BINSEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // rd_addr_q doubles as the pixel counter: it always holds the last address issued.
  assign last_issued = rd_en_q && (rd_addr_q == LAST);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PASS1;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
        end
      end
      PASS1, PASS2: begin
        if (last_issued) begin
          state_d = (state_q == PASS1) ? DRAIN1 : DRAIN2;
        end else if (!stall_w) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN1: state_d = CALC;
      CALC: begin
        if (done_seen_q) begin
          state_d   = PASS2;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
        end
      end
      DRAIN2:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Data arrives one cycle after the read, so histogram/write strobes trail rd_en.
    hist_valid_d = rd_en_q && (state_q == PASS1);
    we_d         = rd_en_q && (state_q == PASS2);
    wr_addr_d    = rd_addr_q;
    thr_start_d  = (state_q == DRAIN1);
    done_seen_d  = (state_q == CALC) && thr_done;
    enable_d     = (state_d == PASS2) || (state_d == DRAIN2);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      hist_valid_q <= 1'b0;
      thr_start_q  <= 1'b0;
      done_seen_q  <= 1'b0;
      enable_q     <= 1'b0;
      we_q         <= 1'b0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      hist_valid_q <= hist_valid_d;
      thr_start_q  <= thr_start_d;
      done_seen_q  <= done_seen_d;
      enable_q     <= enable_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign hist_valid = hist_valid_q;
  assign thr_start  = thr_start_q;
  assign enable     = enable_q;
  assign we         = we_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_binarize_sequencer.sv
// Scoreboard bench for binarize_sequencer: an 8-pixel instance and a 1-pixel instance
// share the clock and reset; stimulus pushes expectations, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_binarize_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_r, thr_r, stall_r;
  int   sel;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start0, start1, thr0, thr1;
  logic [15:0] rd_addr0, rd_addr1, wa0, wa1;
  logic        rd_en0, hv0, ts0, en0, we0, busy0, fd0;
  logic        rd_en1, hv1, ts1, en1, we1, busy1, fd1;

  assign start0 = start_r && (sel == 0);
  assign start1 = start_r && (sel == 1);
  assign thr0   = thr_r && (sel == 0);
  assign thr1   = thr_r && (sel == 1);

`ifdef BINSEQ_STALL_EN
  logic stall0, stall1;
  assign stall0 = stall_r && (sel == 0);
  assign stall1 = stall_r && (sel == 1);
`endif

  binarize_sequencer #(.ADDR_W(16), .NUM_PIXELS(8)) u0 (
    .clk(clk), .rst(rst), .start(start0),
`ifdef BINSEQ_STALL_EN
    .stall(stall0),
`endif
    .thr_done(thr0), .rd_addr(rd_addr0), .rd_en(rd_en0), .hist_valid(hv0),
    .thr_start(ts0), .enable(en0), .we(we0), .wr_addr(wa0), .busy(busy0),
    .frame_done(fd0));

  binarize_sequencer #(.ADDR_W(16), .NUM_PIXELS(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef BINSEQ_STALL_EN
    .stall(stall1),
`endif
    .thr_done(thr1), .rd_addr(rd_addr1), .rd_en(rd_en1), .hist_valid(hv1),
    .thr_start(ts1), .enable(en1), .we(we1), .wr_addr(wa1), .busy(busy1),
    .frame_done(fd1));

  logic [15:0] m_rd_addr, m_wa;
  logic        m_rd_en, m_en, m_we, m_busy, m_fd, m_ts;
  assign m_rd_addr = (sel == 1) ? rd_addr1 : rd_addr0;
  assign m_wa      = (sel == 1) ? wa1 : wa0;
  assign m_rd_en   = (sel == 1) ? rd_en1 : rd_en0;
  assign m_en      = (sel == 1) ? en1 : en0;
  assign m_we      = (sel == 1) ? we1 : we0;
  assign m_busy    = (sel == 1) ? busy1 : busy0;
  assign m_fd      = (sel == 1) ? fd1 : fd0;
  assign m_ts      = (sel == 1) ? ts1 : ts0;

  int n_chk = 0;
  int n_err = 0;
  int q_rd[$], q_wr[$], q_ts[$], q_fd[$];
  int hv_cnt[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Address entries are id*65536+addr, timing entries are id*1000000+cycle.
  task automatic observe(input int id, input logic re, input logic [15:0] ra,
                         input logic hv, input logic ts, input logic en,
                         input logic we, input logic [15:0] wa, input logic fd);
    if (re) begin
      if (q_rd.size() == 0) chk("rd_unexpected", id * 65536 + int'(ra), -1);
      else chk("rd_addr", id * 65536 + int'(ra), q_rd.pop_front());
    end
    if (we) begin
      chk("we_with_enable", int'(en), 1);
      if (q_wr.size() == 0) chk("wr_unexpected", id * 65536 + int'(wa), -1);
      else chk("wr_addr", id * 65536 + int'(wa), q_wr.pop_front());
    end
    if (hv) hv_cnt[id]++;
    if (ts) begin
      if (q_ts.size() == 0) chk("thr_start_unexpected", id * 1000000 + cyc, -1);
      else chk("thr_start_cycle", id * 1000000 + cyc, q_ts.pop_front());
    end
    if (fd) begin
      if (q_fd.size() == 0) chk("frame_done_unexpected", id * 1000000 + cyc, -1);
      else chk("frame_done_cycle", id * 1000000 + cyc, q_fd.pop_front());
      chk("hist_valid_count", hv_cnt[id], (id == 1) ? 1 : 8);
      chk("done_we_enable", int'({we, en}), 0);
      hv_cnt[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    observe(0, rd_en0, rd_addr0, hv0, ts0, en0, we0, wa0, fd0);
    observe(1, rd_en1, rd_addr1, hv1, ts1, en1, we1, wa1, fd1);
    if (rst) begin
      q_rd.delete(); q_wr.delete(); q_ts.delete(); q_fd.delete();
      hv_cnt[0] = 0;
      hv_cnt[1] = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_addr0"}, int'(rd_addr0) + int'(wa0), 0);
    chk({nm, "_flags0"}, int'({rd_en0, hv0, ts0, en0, we0, busy0, fd0}), 0);
    chk({nm, "_addr1"}, int'(rd_addr1) + int'(wa1), 0);
    chk({nm, "_flags1"}, int'({rd_en1, hv1, ts1, en1, we1, busy1, fd1}), 0);
  endtask

  // Issue one frame on the selected instance; w = cycles from thr_start to thr_done.
  task automatic start_frame(input int w, input bit spur, input int stl);
    int np, s, k;
    np = (sel == 1) ? 1 : 8;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < np; a++) q_rd.push_back(sel * 65536 + a);
    for (int a = 0; a < np; a++) q_wr.push_back(sel * 65536 + a);
    s = cyc;
    q_ts.push_back(sel * 1000000 + s + np + 2);
    q_fd.push_back(sel * 1000000 + s + 2 * np + 5 + w + stl);
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    if (spur) begin
      start_r = 1'b1;
      thr_r   = 1'b1;
      tick();
      start_r = 1'b0;
      thr_r   = 1'b0;
    end
    k = 0;
    while (!m_ts && k < 50) begin
      tick();
      k++;
    end
    chk("thr_start_seen", int'(m_ts), 1);
    for (int j = 0; j < w; j++) begin
      if (spur && j == 1) start_r = 1'b1;
      tick();
      start_r = 1'b0;
    end
    thr_r = 1'b1;
    tick();
    thr_r = 1'b0;
`ifdef BINSEQ_STALL_EN
    if (stl > 0) begin
      k = 0;
      while (!(m_en && m_rd_en && m_rd_addr == 16'd4) && k < 50) begin
        tick();
        k++;
      end
      chk("stall_reach", int'(m_rd_addr), 4);
      stall_r = 1'b1;
      tick();
      chk("stall_hold1", int'({m_rd_en, m_rd_addr}), 4);
      tick();
      stall_r = 1'b0;
      chk("stall_hold2", int'({m_rd_en, m_rd_addr}), 4);
    end
`endif
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!m_fd && k < 200) begin
      tick();
      k++;
    end
    chk("frame_done_seen", int'(m_fd), 1);
  endtask

  initial begin
    int k;
    rst = 1'b1; start_r = 1'b0; thr_r = 1'b0; stall_r = 1'b0; sel = 0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Nominal 8-pixel frame, thr_done three cycles after thr_start.
    start_frame(3, 1'b0, 0);
    wait_done();
    repeat (2) tick();

    // Abort in pass 2 once wr_addr=3 has been written, then a clean frame.
    start_frame(0, 1'b0, 0);
    k = 0;
    while (!(m_we && m_wa == 16'd3) && k < 100) begin
      tick();
      k++;
    end
    chk("abort_reach", int'(m_wa), 3);
    rst = 1'b1;
    tick();
    chk_reset_outputs("abort");
    rst = 1'b0;
    repeat (4) tick();
    start_frame(0, 1'b0, 0);
    wait_done();
    tick();

    // Spurious start in PASS1 and CALC, spurious thr_done in PASS1.
    start_frame(3, 1'b1, 0);
    wait_done();
    repeat (10) tick();

    // Back-to-back frames with a single idle cycle between them.
    start_frame(1, 1'b0, 0);
    wait_done();
    chk("b2b_busy_at_done", int'(m_busy), 1);
    tick();
    chk("b2b_idle_gap", int'(m_busy), 0);
    start_frame(2, 1'b0, 0);
    wait_done();
    tick();

    // Single-pixel frame.
    sel = 1;
    start_frame(0, 1'b0, 0);
    wait_done();
    tick();
    sel = 0;

`ifdef BINSEQ_STALL_EN
    start_frame(0, 1'b0, 2);
    wait_done();
    tick();
`endif

    repeat (5) tick();
    chk("queues_empty", q_rd.size() + q_wr.size() + q_ts.size() + q_fd.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/binarize_sequencer.md
Name: binarize_sequencer

Overview:
Two-pass frame sequencer for the binarization datapath; replaces the level-sensitive done/reallydone enable logic with a registered FSM.
- Pass 1 streams every pixel from the input RAM into the histogram/priority-encoder threshold unit.
- The block then waits for the threshold result.
- Pass 2 re-reads every pixel, asserts the output-mux enable and drives write enable/address to the output RAM.
- Sits between the top-level start/done handshake and the RAM/threshold/mux datapath.

Parameters:
ADDR_W, 16, width of pixel address bus
NUM_PIXELS, 65536, pixels per frame (1..2^ADDR_W, need not be a power of 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to process a frame; sampled only in IDLE
rd_addr  out  ADDR_W  input RAM read address
rd_en  out  1  input RAM read strobe; data valid 1 cycle later
hist_valid  out  1  pixel on RAM data bus belongs to pass 1 (feeds histogram)
thr_start  out  1  one-cycle pulse: histogram complete, begin threshold compute
thr_done  in  1  threshold unit result valid (level or pulse)
enable  out  1  output mux select: 1 = binarized pixel to output RAM
we  out  1  output RAM write enable
wr_addr  out  ADDR_W  output RAM write address
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after last write

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - state=IDLE, address counter=0.
  - All outputs 0: rd_addr, rd_en, hist_valid, thr_start, enable, we, wr_addr, busy, frame_done.
  - Reset mid-frame aborts with no further writes.
- All outputs are registered. Input RAM read latency is fixed at 1 cycle.
- IDLE:
  - start=1 -> PASS1, counter=0.
  - busy is high from the next cycle.
- PASS1:
  - rd_en=1, rd_addr=counter; counter increments each cycle.
  - hist_valid is rd_en delayed 1 cycle.
  - After issuing address NUM_PIXELS-1 -> DRAIN1.
- DRAIN1:
  - 1 cycle with rd_en=0 and hist_valid=1 for the last pixel.
  - Then -> CALC with thr_start pulsed in the first CALC cycle.
- CALC:
  - Wait for thr_done=1.
  - thr_done seen in any other state is ignored.
  - thr_done coincident with the thr_start pulse is accepted in the following cycle.
  - -> PASS2, counter=0.
- PASS2:
  - rd_en=1, rd_addr=counter, counter increments.
  - enable=1 for the whole of PASS2 and DRAIN2.
  - we is rd_en delayed 1 cycle; wr_addr is rd_addr delayed 1 cycle.
  - After issuing NUM_PIXELS-1 -> DRAIN2.
- DRAIN2:
  - Final write (we=1, wr_addr=NUM_PIXELS-1).
  - -> DONE.
- DONE:
  - frame_done=1 for exactly 1 cycle; we=0; enable=0.
  - -> IDLE.
- start while busy=1 is ignored (not queued).
- Back-to-back frames: start in the cycle after frame_done starts the next frame normally.
- Counter is ADDR_W bits and is compared against NUM_PIXELS-1, so it never wraps.
- NUM_PIXELS=1 is legal: PASS1 lasts 1 cycle.
- Exactly NUM_PIXELS reads per pass and NUM_PIXELS writes per frame.
- Frame latency, start to frame_done (no stall): 2*NUM_PIXELS + 5 + (cycles waiting in CALC).

Optional Feature:
BINSEQ_STALL_EN
- Defined: adds input port stall (1 bit).
  - While stall=1 in PASS1/PASS2: counter holds, rd_en=0, and the delayed hist_valid/we follow rd_en, so there are no duplicate or skipped addresses.
  - DRAIN/CALC/DONE are unaffected.
  - rst overrides stall.
- Undefined: no stall port; reads issue every cycle of PASS1/PASS2.

Test Plan:
- NUM_PIXELS=8, rst then start; thr_done 3 cycles after thr_start -> rd_addr 0..7 twice; 8 hist_valid pulses; thr_start exactly once; we high 8 cycles with wr_addr 0..7; frame_done at cycle 2*8+5+3 after start.
- rst=1 in the middle of PASS2 (after wr_addr=3) -> next cycle all outputs 0, state IDLE; a new start runs a full clean frame.
- start pulsed during PASS1 and CALC; thr_done pulsed during PASS1 -> ignored; exactly one frame; CALC still waits for a real thr_done.
- NUM_PIXELS=1 -> one read per pass; one write at wr_addr=0; frame_done pulses once.
- start asserted in the cycle after frame_done -> second frame starts with busy continuous except one IDLE cycle; addresses restart at 0.
- BINSEQ_STALL_EN: stall=1 for 2 cycles at rd_addr=4 in PASS2 -> rd_addr held at 4; we=0 for 2 cycles; wr_addr sequence 0..7 with no gaps or repeats.
